fetch_pc_gen: RTL and testbench
===============================

FETCH_PC_GEN -- requirements
Module: fetch_pc_gen

Interface
REQ-001: Parameter RESET_PC, default 32'h0000_0000, first fetch address after reset.
REQ-002: clk  input  1  clock; all state updates on posedge.
REQ-003: rst_n  input  1  reset, asynchronous, active-low.
REQ-004: if_req_valid  output  1  instruction-memory request valid.
REQ-005: if_req_addr  output  32  request address, equal to current PC.
REQ-006: if_req_ready  input  1  memory accepts request when high with if_req_valid.
REQ-007: if_rsp_valid  input  1  instruction response valid, one per accepted request, at least 1 cycle after acceptance.
REQ-008: if_rsp_data  input  32  fetched instruction.
REQ-009: bp_addr  output  8  predictor read index = PC[9:2], driven every cycle.
REQ-010: bp_taken  input  1  registered prediction for the bp_addr of the previous cycle.
REQ-011: dec_valid / dec_ready  output / input  1 / 1  valid-ready handshake to decode.
REQ-012: dec_instr, dec_pc  output  32 each  instruction and its PC.
REQ-013: dec_pred_taken  output  1  prediction used to select next PC.
REQ-014: ex_redirect  input  1  execute-stage mispredict/exception redirect pulse.
REQ-015: ex_redirect_pc  input  32  redirect target.

Function
REQ-016: FSM states REQ (drive if_req_valid), WAIT (one request outstanding), HOLD (response latched, decode not ready); one outstanding request maximum.
REQ-017: REQ->WAIT on if_req_valid && if_req_ready; PC and bp_addr stay stable from REQ entry until the response is consumed.
REQ-018: WAIT on if_rsp_valid: latch instruction, PC, bp_taken; dec_valid rises next cycle; go HOLD.
REQ-019: HOLD->REQ on dec_valid && dec_ready, PC updated to next PC same edge.
REQ-020: Next PC: opcode 7'b1100011 with bp_taken -> PC + B-imm (sign-extended, bit0=0); opcode 7'b1101111 -> PC + J-imm, dec_pred_taken=1; otherwise PC + 4; dec_pred_taken=0 for non-branches.
REQ-021: All PC arithmetic modulo 2^32; wrap from 32'hFFFF_FFFC to 0 without error.
REQ-022: ex_redirect has priority over every other event: next edge PC <= ex_redirect_pc, state <= REQ, dec_valid <= 0.
REQ-023: Redirect in WAIT sets a drop flag; the outstanding response is consumed and discarded; no new request until it arrives, then state REQ with redirected PC.
REQ-024: Redirect coincident with if_rsp_valid discards that response; coincident with dec handshake, the handshake completes but PC takes ex_redirect_pc.
REQ-025: dec_instr/dec_pc/dec_pred_taken stable while dec_valid && !dec_ready.

Reset
REQ-026: On rst_n low: PC=RESET_PC, state=REQ, drop flag=0, dec_valid=0, dec_instr=32'h0000_0013, dec_pc=0, dec_pred_taken=0, if_req_valid=0 for first cycle after release then 1.
REQ-027: Reset mid-transaction abandons outstanding request; environment discards its response.

Configuration
REQ-028: Macro FETCH_STATS_EN defined: outputs stat_fetched, stat_pred_taken, stat_redirects (32 bits, saturating, reset 0) count delivered instructions, taken predictions delivered, ex_redirect pulses.
REQ-029: FETCH_STATS_EN undefined: same ports present, tied to 0, no counter logic.

Structure
REQ-030: Package fetch_pkg holds opcode constants OP_BRANCH, OP_JAL, NOP_INSTR and state enum fetch_state_t.
REQ-031: Sub-module fetch_imm_dec (combinational) extracts B/J immediates and branch type.

Verification
REQ-032: Reset release, ready always 1, rsp latency 1, NOP stream -> addresses 0,4,8,12; bp_addr 0,1,2,3.
REQ-033: PC 0x100 BEQ imm +0x40, bp_taken=1 -> next if_req_addr 0x140, dec_pred_taken=1; bp_taken=0 -> 0x104.
REQ-034: JAL imm -8 at 0x200 -> next address 0x1F8 regardless of bp_taken.
REQ-035: ex_redirect to 0x800 during WAIT, rsp 3 cycles later -> response dropped, dec_valid stays 0, next request 0x800.
REQ-036: dec_ready low 5 cycles -> dec outputs stable, no new request; PC 0xFFFF_FFFC NOP -> next 0x0.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared constants and types for the instruction fetch PC generator.
package fetch_pkg;

  localparam logic [6:0]  OP_BRANCH = 7'b1100011;
  localparam logic [6:0]  OP_JAL    = 7'b1101111;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  // REQ: driving a request; WAIT: one request outstanding; HOLD: instruction
  // latched and offered to decode.
  typedef enum logic [1:0] {
    ST_REQ  = 2'd0,
    ST_WAIT = 2'd1,
    ST_HOLD = 2'd2
  } fetch_state_t;

  // Control-flow class of a fetched instruction, as far as fetch cares.
  typedef enum logic [1:0] {
    BR_NONE = 2'd0,
    BR_COND = 2'd1,
    BR_JAL  = 2'd2
  } br_kind_t;

endpackage

// File: rtl/fetch_imm_dec.sv
// Combinational extraction of the B- and J-type immediates and the
// control-flow class of a 32-bit instruction word.
module fetch_imm_dec
  import fetch_pkg::*;
(
  input  logic [31:0] i_instr,
  output logic [31:0] o_b_imm,
  output logic [31:0] o_j_imm,
  output br_kind_t    o_kind
);

  // Immediates are sign-extended and always even (bit 0 forced to zero).
  assign o_b_imm = {{19{i_instr[31]}}, i_instr[31], i_instr[7],
                    i_instr[30:25], i_instr[11:8], 1'b0};
  assign o_j_imm = {{11{i_instr[31]}}, i_instr[31], i_instr[19:12],
                    i_instr[20], i_instr[30:21], 1'b0};

  // Classify by opcode only; funct3 does not change the fetch target.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can
    // leave it unassigned and infer a latch.
    o_kind = BR_NONE;
    case (i_instr[6:0])
      OP_BRANCH: o_kind = BR_COND;
      OP_JAL:    o_kind = BR_JAL;
      default:   o_kind = BR_NONE;
    endcase
  end

endmodule

// File: rtl/fetch_pc_gen.sv
// Fetch PC generator: issues one instruction-memory request at a time,
// hands the returned instruction to decode, and selects the next PC from a
// static JAL decode or the branch predictor. Execute redirects win over all.
// Optional macro FETCH_STATS_EN adds saturating fetch/prediction/redirect
// counters; without it the stat ports read as zero.
module fetch_pc_gen
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        if_req_valid,
  output logic [31:0] if_req_addr,
  input  logic        if_req_ready,
  input  logic        if_rsp_valid,
  input  logic [31:0] if_rsp_data,
  output logic [7:0]  bp_addr,
  input  logic        bp_taken,
  output logic        dec_valid,
  input  logic        dec_ready,
  output logic [31:0] dec_instr,
  output logic [31:0] dec_pc,
  output logic        dec_pred_taken,
  input  logic        ex_redirect,
  input  logic [31:0] ex_redirect_pc,
  output logic [31:0] stat_fetched,
  output logic [31:0] stat_pred_taken,
  output logic [31:0] stat_redirects
);

  fetch_state_t r_state, w_state_nxt;
  logic         r_drop, w_drop_nxt;
  logic         r_started;
  logic [31:0]  r_pc, r_next_pc, w_next_pc;
  logic         r_dec_valid, r_dec_pred;
  logic [31:0]  r_dec_instr, r_dec_pc;
  logic         w_req_fire, w_dec_fire, w_rsp_take, w_pred;
  logic [31:0]  w_b_imm, w_j_imm;
  br_kind_t     w_kind;

  // Decode the response as it arrives so the next PC is ready at latch time.
  fetch_imm_dec u_imm_dec (
    .i_instr (if_rsp_data),
    .o_b_imm (w_b_imm),
    .o_j_imm (w_j_imm),
    .o_kind  (w_kind)
  );

  // No request in the first cycle after reset, nor while a stale response
  // is still owed to us after a redirect.
  assign if_req_valid   = (r_state == ST_REQ) && r_started && !r_drop;
  assign if_req_addr    = r_pc;
  assign bp_addr        = r_pc[9:2];
  assign dec_valid      = r_dec_valid;
  assign dec_instr      = r_dec_instr;
  assign dec_pc         = r_dec_pc;
  assign dec_pred_taken = r_dec_pred;

  assign w_req_fire = if_req_valid && if_req_ready;
  assign w_dec_fire = r_dec_valid && dec_ready;
  assign w_rsp_take = (r_state == ST_WAIT) && if_rsp_valid;

  // Prediction and target for the instruction being latched this cycle.
  always_comb begin
    w_pred    = 1'b0;
    w_next_pc = r_pc + 32'd4;
    case (w_kind)
      BR_JAL: begin
        w_pred    = 1'b1;
        w_next_pc = r_pc + w_j_imm;
      end
      BR_COND: begin
        w_pred = bp_taken;
        if (bp_taken) w_next_pc = r_pc + w_b_imm;
      end
      default: ;
    endcase
  end

  // FSM state and drop flag register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_REQ;
      r_drop  <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every flop
      // samples pre-edge values regardless of block ordering.
      r_state <= w_state_nxt;
      r_drop  <= w_drop_nxt;
    end
  end

  // Next-state logic; a redirect pre-empts everything and owes a drop if a
  // request is (or is just becoming) outstanding without its response now.
  always_comb begin
    w_state_nxt = r_state;
    w_drop_nxt  = r_drop;
    if (ex_redirect) begin
      w_state_nxt = ST_REQ;
      if ((r_state == ST_WAIT) || r_drop) w_drop_nxt = !if_rsp_valid;
      else                                w_drop_nxt = w_req_fire;
    end else begin
      case (r_state)
        ST_REQ: begin
          if (r_drop) begin
            if (if_rsp_valid) w_drop_nxt = 1'b0;
          end else if (w_req_fire) begin
            w_state_nxt = ST_WAIT;
          end
        end
        ST_WAIT: if (if_rsp_valid) w_state_nxt = ST_HOLD;
        ST_HOLD: if (w_dec_fire)   w_state_nxt = ST_REQ;
        default: w_state_nxt = ST_REQ;
      endcase
    end
  end

  // PC, decode output registers and the post-reset request gate.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_started   <= 1'b0;
      r_pc        <= RESET_PC;
      r_next_pc   <= RESET_PC;
      r_dec_valid <= 1'b0;
      r_dec_instr <= NOP_INSTR;
      r_dec_pc    <= 32'h0;
      r_dec_pred  <= 1'b0;
    end else begin
      r_started <= 1'b1;
      if (ex_redirect) begin
        r_pc        <= ex_redirect_pc;
        r_dec_valid <= 1'b0;
      end else begin
        if (w_rsp_take) begin
          r_dec_valid <= 1'b1;
          r_dec_instr <= if_rsp_data;
          r_dec_pc    <= r_pc;
          r_dec_pred  <= w_pred;
          r_next_pc   <= w_next_pc;
        end
        if (w_dec_fire) begin
          r_dec_valid <= 1'b0;
          r_pc        <= r_next_pc;
        end
      end
    end
  end

`ifdef FETCH_STATS_EN
  logic [31:0] r_stat_fetched, r_stat_pred_taken, r_stat_redirects;

  // Saturating event counters for delivered instructions, delivered taken
  // predictions and redirect pulses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stat_fetched    <= 32'h0;
      r_stat_pred_taken <= 32'h0;
      r_stat_redirects  <= 32'h0;
    end else begin
      if (w_dec_fire && (r_stat_fetched != '1))
        r_stat_fetched <= r_stat_fetched + 32'd1;
      if (w_dec_fire && r_dec_pred && (r_stat_pred_taken != '1))
        r_stat_pred_taken <= r_stat_pred_taken + 32'd1;
      if (ex_redirect && (r_stat_redirects != '1))
        r_stat_redirects <= r_stat_redirects + 32'd1;
    end
  end

  assign stat_fetched    = r_stat_fetched;
  assign stat_pred_taken = r_stat_pred_taken;
  assign stat_redirects  = r_stat_redirects;
`else
  assign stat_fetched    = 32'h0;
  assign stat_pred_taken = 32'h0;
  assign stat_redirects  = 32'h0;
`endif

endmodule

// File: tb/tb_fetch_pc_gen.sv
// Directed scoreboard bench for fetch_pc_gen: a small memory model answers
// accepted requests after a programmable latency; expected requests and
// decode deliveries are queued by the stimulus and popped on handshakes.
`timescale 1ns/1ps
module tb_fetch_pc_gen;

  localparam logic [31:0] NOP  = 32'h0000_0013;
  localparam logic [31:0] ADDI = 32'h0050_0093;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        if_req_valid;
  logic [31:0] if_req_addr;
  logic        if_req_ready;
  logic        if_rsp_valid;
  logic [31:0] if_rsp_data;
  logic [7:0]  bp_addr;
  logic        bp_taken;
  logic        dec_valid;
  logic        dec_ready;
  logic [31:0] dec_instr;
  logic [31:0] dec_pc;
  logic        dec_pred_taken;
  logic        ex_redirect;
  logic [31:0] ex_redirect_pc;
  logic [31:0] stat_fetched, stat_pred_taken, stat_redirects;

  fetch_pc_gen #(.RESET_PC(32'h0000_0000)) dut (
    .clk(clk), .rst_n(rst_n),
    .if_req_valid(if_req_valid), .if_req_addr(if_req_addr),
    .if_req_ready(if_req_ready), .if_rsp_valid(if_rsp_valid),
    .if_rsp_data(if_rsp_data), .bp_addr(bp_addr), .bp_taken(bp_taken),
    .dec_valid(dec_valid), .dec_ready(dec_ready), .dec_instr(dec_instr),
    .dec_pc(dec_pc), .dec_pred_taken(dec_pred_taken),
    .ex_redirect(ex_redirect), .ex_redirect_pc(ex_redirect_pc),
    .stat_fetched(stat_fetched), .stat_pred_taken(stat_pred_taken),
    .stat_redirects(stat_redirects)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic        pred;
  } dec_exp_t;

  typedef struct packed {
    logic [31:0] addr;
    logic [7:0]  cnt;
  } pend_t;

  logic [31:0] q_req[$];
  dec_exp_t    q_dec[$];
  pend_t       q_pend[$];
  logic [31:0] imem [logic [31:0]];
  int          rsp_lat = 1;
  int          n_vec = 0, n_err = 0;
  int          n_deliv = 0, n_pt = 0, n_redir = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] enc_b(input logic [12:0] imm);
    return {imm[12], imm[10:5], 5'd0, 5'd0, 3'b000, imm[4:1], imm[11], 7'b1100011};
  endfunction

  function automatic logic [31:0] enc_j(input logic [20:0] imm);
    return {imm[20], imm[10:1], imm[11], imm[19:12], 5'd0, 7'b1101111};
  endfunction

  function automatic logic [31:0] fetch_word(input logic [31:0] a);
    return imem.exists(a) ? imem[a] : NOP;
  endfunction

  // Called just after a falling edge with all inputs final: score the
  // handshakes about to happen, cross the rising edge, then update the
  // memory model for the new cycle.
  task automatic step();
    logic [31:0] ea;
    dec_exp_t    ed;
    pend_t       p;
    if (if_req_valid && if_req_ready) begin
      if (q_req.size() == 0) begin
        check("req_unexpected", {31'b0, if_req_valid}, 32'h0);
      end else begin
        ea = q_req.pop_front();
        check("req_addr", if_req_addr, ea);
        check("bp_addr", {24'b0, bp_addr}, {24'b0, ea[9:2]});
      end
      p.addr = if_req_addr;
      p.cnt  = 8'(rsp_lat);
      q_pend.push_back(p);
    end
    if (dec_valid && dec_ready) begin
      if (q_dec.size() == 0) begin
        check("dec_unexpected", {31'b0, dec_valid}, 32'h0);
      end else begin
        ed = q_dec.pop_front();
        check("dec_pc", dec_pc, ed.pc);
        check("dec_instr", dec_instr, ed.instr);
        check("dec_pred", {31'b0, dec_pred_taken}, {31'b0, ed.pred});
        n_deliv++;
        if (ed.pred) n_pt++;
      end
    end
    if (ex_redirect) n_redir++;
    @(posedge clk);
    @(negedge clk);
    if_rsp_valid = 1'b0;
    if_rsp_data  = 32'h0;
    if (q_pend.size() > 0) begin
      q_pend[0].cnt = q_pend[0].cnt - 8'd1;
      if (q_pend[0].cnt == 8'd0) begin
        p = q_pend.pop_front();
        if_rsp_valid = 1'b1;
        if_rsp_data  = fetch_word(p.addr);
      end
    end
  endtask

  task automatic run(input string tag);
    int b = 0;
    while ((q_req.size() != 0 || q_dec.size() != 0) && b < 200) begin
      step();
      b++;
    end
    check($sformatf("%s_pending", tag), 32'(q_req.size() + q_dec.size()), 32'h0);
  endtask

  task automatic redirect(input logic [31:0] pc);
    ex_redirect    = 1'b1;
    ex_redirect_pc = pc;
    step();
    ex_redirect    = 1'b0;
  endtask

  task automatic expect_pair(input logic [31:0] pc, input logic [31:0] instr, input logic pred);
    dec_exp_t e;
    e.pc = pc; e.instr = instr; e.pred = pred;
    q_req.push_back(pc);
    q_dec.push_back(e);
  endtask

  initial begin
    dec_exp_t e;
    int       b;
    rst_n = 1'b1; if_req_ready = 1'b0; if_rsp_valid = 1'b0; if_rsp_data = 32'h0;
    bp_taken = 1'b0; dec_ready = 1'b0; ex_redirect = 1'b0; ex_redirect_pc = 32'h0;
    imem[32'h100] = enc_b(13'h040);
    imem[32'h200] = enc_j(-21'sd8);
    imem[32'h300] = enc_j(21'h000100);
    imem[32'h400] = ADDI;

    #2 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_req_valid", {31'b0, if_req_valid}, 32'h0);
    check("rst_req_addr", if_req_addr, 32'h0);
    check("rst_dec_valid", {31'b0, dec_valid}, 32'h0);
    check("rst_dec_instr", dec_instr, NOP);
    check("rst_dec_pc", dec_pc, 32'h0);
    check("rst_dec_pred", {31'b0, dec_pred_taken}, 32'h0);
    check("rst_stat_fetched", stat_fetched, 32'h0);
    check("rst_stat_redirects", stat_redirects, 32'h0);
    rst_n = 1'b1;
    #1;
    check("first_cycle_req_valid", {31'b0, if_req_valid}, 32'h0);

    // Sequential NOP stream from reset.
    if_req_ready = 1'b1; dec_ready = 1'b1;
    for (int i = 0; i < 4; i++) expect_pair(32'(4 * i), NOP, 1'b0);
    run("nop_stream");
    if_req_ready = 1'b0;

    // Conditional branch at 0x100, predicted taken then not taken.
    for (int t = 1; t >= 0; t--) begin
      bp_taken = t[0];
      redirect(32'h100);
      expect_pair(32'h100, enc_b(13'h040), t[0]);
      expect_pair(t[0] ? 32'h140 : 32'h104, NOP, 1'b0);
      if_req_ready = 1'b1;
      run("beq");
      if_req_ready = 1'b0;
    end

    // JAL -8 at 0x200 ignores the predictor.
    for (int t = 1; t >= 0; t--) begin
      bp_taken = t[0];
      redirect(32'h200);
      expect_pair(32'h200, enc_j(-21'sd8), 1'b1);
      expect_pair(32'h1F8, NOP, 1'b0);
      if_req_ready = 1'b1;
      run("jal");
      if_req_ready = 1'b0;
    end

    // Redirect while the 0x300 fetch is outstanding; its response is dropped.
    bp_taken = 1'b0;
    rsp_lat  = 3;
    redirect(32'h300);
    q_req.push_back(32'h300);
    if_req_ready = 1'b1;
    step();
    redirect(32'h800);
    check("drop_req_valid_a", {31'b0, if_req_valid}, 32'h0);
    check("drop_dec_valid_a", {31'b0, dec_valid}, 32'h0);
    step();
    check("drop_req_valid_b", {31'b0, if_req_valid}, 32'h0);
    step();
    check("drop_dec_valid_c", {31'b0, dec_valid}, 32'h0);
    rsp_lat = 1;
    expect_pair(32'h800, NOP, 1'b0);
    run("after_drop");
    if_req_ready = 1'b0;

    // Decode back-pressure for 5 cycles, then redirect during the handshake.
    redirect(32'h400);
    q_req.push_back(32'h400);
    if_req_ready = 1'b1;
    dec_ready    = 1'b0;
    run("stall_req");
    b = 0;
    while (!dec_valid && b < 20) begin step(); b++; end
    check("stall_dec_valid", {31'b0, dec_valid}, 32'h1);
    for (int i = 0; i < 5; i++) begin
      check("stall_dec_pc", dec_pc, 32'h400);
      check("stall_dec_instr", dec_instr, ADDI);
      check("stall_req_valid", {31'b0, if_req_valid}, 32'h0);
      step();
    end
    dec_ready = 1'b1;
    e.pc = 32'h400; e.instr = ADDI; e.pred = 1'b0;
    q_dec.push_back(e);
    expect_pair(32'h600, NOP, 1'b0);
    redirect(32'h600);
    run("redirect_at_handshake");
    if_req_ready = 1'b0;

    // PC wraps from the top of the address space to zero.
    redirect(32'hFFFF_FFFC);
    expect_pair(32'hFFFF_FFFC, NOP, 1'b0);
    expect_pair(32'h0, NOP, 1'b0);
    if_req_ready = 1'b1;
    run("wrap");
    if_req_ready = 1'b0;
    step();

`ifdef FETCH_STATS_EN
    check("stat_fetched", stat_fetched, 32'(n_deliv));
    check("stat_pred_taken", stat_pred_taken, 32'(n_pt));
    check("stat_redirects", stat_redirects, 32'(n_redir));
`else
    check("stat_fetched", stat_fetched, 32'h0);
    check("stat_pred_taken", stat_pred_taken, 32'h0);
    check("stat_redirects", stat_redirects, 32'h0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

endmodule
